// File: rtl/rgb_lcd_capture.sv
// rgb_lcd_capture: sink for the parallel RGB LCD bus driven by the LCD timing
// generator. It registers the bus and packs active pixels to RGB565 for a
// downstream FIFO. It also measures the active geometry of each frame and
// flags lock when that geometry matches the expected size.
module rgb_lcd_capture #(
    parameter int unsigned EXP_WIDTH    = 800,
    parameter int unsigned EXP_HEIGHT   = 480,
    parameter int unsigned CNT_W        = 16,
    parameter logic        VS_POL       = 1'b1,
    parameter int unsigned FIFO_RST_LEN = 20
) (
    input  logic             nRST,
    input  logic             PixelClk,
    input  logic             LCD_DE,
    input  logic             LCD_HSYNC,
    input  logic             LCD_VSYNC,
    input  logic [7:0]       LCD_R,
    input  logic [7:0]       LCD_G,
    input  logic [7:0]       LCD_B,
    output logic             FIFO_RST,
    output logic             FIFO_WE,
    output logic [15:0]      FIFO_Data,
    input  logic             FIFO_Full,
    input  logic             Clr_Ovf,
    output logic             Frame_Start,
    output logic [CNT_W-1:0] Frame_Width,
    output logic [CNT_W-1:0] Frame_Height,
    output logic             Locked,
    output logic             Overflow
);

    localparam int unsigned      RW       = $clog2(FIFO_RST_LEN + 1);
    localparam logic [RW-1:0]    RST_LOAD = RW'(FIFO_RST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_W_C  = CNT_W'(EXP_WIDTH);
    localparam logic [CNT_W-1:0] EXP_H_C  = CNT_W'(EXP_HEIGHT);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    // Truncating 8:8:8 -> 5:6:5 pack; the low colour bits are dropped.
    function automatic logic [15:0] pack565(input logic [7:0] r,
                                            input logic [7:0] g,
                                            input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // Saturating counter increment; holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_q, state_d;
    logic             de_p1_q, hs_p1_q, vs_p1_q;
    logic             de_p2_q, vs_p2_q;
    logic [7:0]       r_p1_q, g_p1_q, b_p1_q;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] line0_w_q, line0_w_d;
    logic             bad_q, bad_d;
    logic             fifo_we_q, fifo_we_d;
    logic [15:0]      fifo_data_q, fifo_data_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] height_q, height_d;
    logic             locked_q, locked_d;
    logic             ovf_q, ovf_d;

    logic             vs_edge, de_rise, de_fall;
    logic             cap_en, eof, empty_eof;
    logic             wr_req, first_fall, bad_set, frame_bad;
    logic [CNT_W-1:0] line0_w_now;

    // ---- stage p1/p2: bus sample and edge-detect history (control) ----
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_p1_q <= 1'b0;
            hs_p1_q <= 1'b1;
            vs_p1_q <= ~VS_POL;
            de_p2_q <= 1'b0;
            vs_p2_q <= ~VS_POL;
        end else begin
            de_p1_q <= LCD_DE;
            hs_p1_q <= LCD_HSYNC;
            vs_p1_q <= LCD_VSYNC;
            de_p2_q <= de_p1_q;
            vs_p2_q <= vs_p1_q;
        end
    end

    // Colour sample at p1; pure data, so it carries no reset.
    always_ff @(posedge PixelClk) begin
        r_p1_q <= LCD_R;
        g_p1_q <= LCD_G;
        b_p1_q <= LCD_B;
    end

    assign vs_edge     = (vs_p1_q == VS_POL) && (vs_p2_q != VS_POL);
    assign de_rise     = de_p1_q && !de_p2_q;
    assign de_fall     = !de_p1_q && de_p2_q;
    assign Frame_Start = vs_edge;
    // The flush window opens in the edge cycle itself, then the counter holds it.
    assign FIFO_RST    = vs_edge || (rst_cnt_q != '0);

    // FSM register.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) state_q <= WAIT_VS;
        else       state_q <= state_d;
    end

    // Next state plus per-cycle frame decode: capture enable and end-of-frame.
    always_comb begin
        state_d   = state_q;
        cap_en    = 1'b0;
        eof       = 1'b0;
        empty_eof = 1'b0;
        unique case (state_q)
            WAIT_VS: begin
                if (vs_edge) state_d = VBLANK;
            end
            VBLANK: begin
                if (vs_edge) begin
                    empty_eof = 1'b1;
                end else if (de_rise) begin
                    state_d = ACTIVE;
                    cap_en  = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_edge) begin
                    state_d = VBLANK;
                    eof     = 1'b1;
                end else begin
                    cap_en = 1'b1;
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    // Flush-window countdown; a fresh VSYNC edge restarts it.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (vs_edge)                rst_cnt_d = RST_LOAD;
        else if (rst_cnt_q != '0)   rst_cnt_d = rst_cnt_q - RW'(1);
    end

    // Geometry counters and the frame-bad flag.
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        line0_w_d   = line0_w_q;
        bad_d       = bad_q;
        bad_set     = 1'b0;
        wr_req      = cap_en && de_p1_q && !FIFO_RST;
        first_fall  = (state_q == ACTIVE) && de_fall && (line_cnt_q == CNT_ONE);
        line0_w_now = first_fall ? pix_cnt_q : line0_w_q;

        if (cap_en && de_p1_q) begin
            if (de_rise) begin
                pix_cnt_d = CNT_ONE;
            end else begin
                if (pix_cnt_q == CNT_MAX) bad_set = 1'b1;
                pix_cnt_d = sat_inc(pix_cnt_q);
            end
            // HSYNC must stay idle while pixels are valid.
            if (!hs_p1_q) bad_set = 1'b1;
        end
        if (cap_en && de_rise) begin
            if (line_cnt_q == CNT_MAX) bad_set = 1'b1;
            line_cnt_d = sat_inc(line_cnt_q);
        end
        // A fall closes a line: the first sets the reference, later ones must match.
        if ((state_q == ACTIVE) && de_fall) begin
            if (first_fall)                   line0_w_d = pix_cnt_q;
            else if (pix_cnt_q != line0_w_q)  bad_set   = 1'b1;
        end
        if (wr_req && FIFO_Full) bad_set = 1'b1;
        // VSYNC arriving mid-line aborts that line.
        if (eof && de_p1_q) bad_set = 1'b1;

        frame_bad = bad_q || bad_set;

        if (vs_edge) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            line0_w_d  = '0;
            bad_d      = 1'b0;
        end else if (bad_set) begin
            bad_d = 1'b1;
        end
    end

    // Write strobe, frame report and overflow flag.
    always_comb begin
        fifo_we_d   = wr_req && !FIFO_Full;
        fifo_data_d = fifo_data_q;
        width_d     = width_q;
        height_d    = height_q;
        locked_d    = locked_q;
        ovf_d       = ovf_q;
        if (fifo_we_d) fifo_data_d = pack565(r_p1_q, g_p1_q, b_p1_q);
        if (eof) begin
            width_d  = line0_w_now;
            height_d = line_cnt_q;
            locked_d = !frame_bad && (line0_w_now == EXP_W_C) && (line_cnt_q == EXP_H_C);
        end else if (empty_eof) begin
            width_d  = '0;
            height_d = '0;
            locked_d = 1'b0;
        end
        // A new drop outranks a clear in the same cycle.
        if (wr_req && FIFO_Full) ovf_d = 1'b1;
        else if (Clr_Ovf)        ovf_d = 1'b0;
    end

    // ---- stage p2: counters, flush timer and registered outputs ----
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            rst_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            line0_w_q   <= '0;
            bad_q       <= 1'b0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
            width_q     <= '0;
            height_q    <= '0;
            locked_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rst_cnt_q   <= rst_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            line0_w_q   <= line0_w_d;
            bad_q       <= bad_d;
            fifo_we_q   <= fifo_we_d;
            fifo_data_q <= fifo_data_d;
            width_q     <= width_d;
            height_q    <= height_d;
            locked_q    <= locked_d;
            ovf_q       <= ovf_d;
        end
    end

    assign FIFO_WE      = fifo_we_q;
    assign FIFO_Data    = fifo_data_q;
    assign Frame_Width  = width_q;
    assign Frame_Height = height_q;
    assign Locked       = locked_q;
    assign Overflow     = ovf_q;

endmodule

// File: tb/tb_rgb_lcd_capture.sv
// Directed bench for rgb_lcd_capture with an 8x4 expected geometry.
module tb_rgb_lcd_capture;

    logic        nRST = 1'b0;
    logic        PixelClk = 1'b0;
    logic        LCD_DE = 1'b0, LCD_HSYNC = 1'b1, LCD_VSYNC = 1'b0;
    logic [7:0]  LCD_R = 8'h00, LCD_G = 8'h00, LCD_B = 8'h00;
    logic        FIFO_RST, FIFO_WE, Frame_Start, Locked, Overflow;
    logic [15:0] FIFO_Data, Frame_Width, Frame_Height;
    logic        FIFO_Full = 1'b0, Clr_Ovf = 1'b0;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, rst_cycles = 0, we_in_rst = 0;
    logic [15:0] last_data = 16'h0;
    int b_wr, b_rst, b_wir;

    always #5 PixelClk = ~PixelClk;

    rgb_lcd_capture #(
        .EXP_WIDTH(8), .EXP_HEIGHT(4), .CNT_W(16), .VS_POL(1'b1), .FIFO_RST_LEN(20)
    ) dut (
        .nRST(nRST), .PixelClk(PixelClk),
        .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .FIFO_RST(FIFO_RST), .FIFO_WE(FIFO_WE), .FIFO_Data(FIFO_Data),
        .FIFO_Full(FIFO_Full), .Clr_Ovf(Clr_Ovf), .Frame_Start(Frame_Start),
        .Frame_Width(Frame_Width), .Frame_Height(Frame_Height),
        .Locked(Locked), .Overflow(Overflow)
    );

    // Output monitor on the falling edge.
    always @(negedge PixelClk) begin
        if (FIFO_WE) begin
            wr_cnt = wr_cnt + 1;
            last_data = FIFO_Data;
        end
        if (FIFO_RST) rst_cycles = rst_cycles + 1;
        if (FIFO_WE && FIFO_RST) we_in_rst = we_in_rst + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PixelClk);
            #1;
        end
    endtask

    task automatic vs_pulse();
        LCD_VSYNC = 1'b1;
        tick(3);
        LCD_VSYNC = 1'b0;
        tick(25);
    endtask

    // Pixel i sees FIFO_Full during iterations fs..fs+fl-1 (shifted one by the input register).
    task automatic send_line(input int n, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input int fs, input int fl);
        LCD_R = r; LCD_G = g; LCD_B = b;
        LCD_DE = 1'b1;
        for (int i = 0; i < n; i++) begin
            FIFO_Full = (i >= fs) && (i < fs + fl);
            tick(1);
        end
        FIFO_Full = 1'b0;
        LCD_DE = 1'b0;
        tick(1);
        LCD_HSYNC = 1'b0;
        tick(1);
        LCD_HSYNC = 1'b1;
        tick(3);
    endtask

    task automatic send_frame(input int short_idx, input int short_w,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int l = 0; l < 4; l++)
            send_line((l == short_idx) ? short_w : 8, r, g, b, 0, 0);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        tick(3);
        checks++;
        if ({FIFO_WE, FIFO_RST, Frame_Start, Locked, Overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {FIFO_WE, FIFO_RST, Frame_Start, Locked, Overflow});
        end
        checks++;
        if ({Frame_Width, Frame_Height, FIFO_Data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_words: got w=%0d h=%0d d=%h want 0", Frame_Width, Frame_Height, FIFO_Data);
        end
        nRST = 1'b1;
        tick(2);
    endtask

    task automatic test_wait_vs();
        b_wr = wr_cnt; b_rst = rst_cycles;
        send_line(8, 8'hFF, 8'hFF, 8'hFF, 0, 0);
        send_line(8, 8'hFF, 8'hFF, 8'hFF, 0, 0);
        checks++;
        if (wr_cnt - b_wr !== 0) begin
            errors++;
            $display("FAIL wait_vs_writes: got %0d want 0", wr_cnt - b_wr);
        end
        checks++;
        if (rst_cycles - b_rst !== 0) begin
            errors++;
            $display("FAIL wait_vs_fifo_rst: got %0d cycles want 0", rst_cycles - b_rst);
        end
    endtask

    task automatic test_clean_frames();
        vs_pulse();
        checks++;
        if (Locked !== 1'b0 || Frame_Height !== 16'd0) begin
            errors++;
            $display("FAIL first_edge_report: got locked=%b h=%0d want 0 0", Locked, Frame_Height);
        end
        b_wr = wr_cnt;
        send_frame(-1, 0, 8'hFF, 8'h80, 8'h08);
        checks++;
        if (wr_cnt - b_wr !== 32) begin
            errors++;
            $display("FAIL clean1_writes: got %0d want 32", wr_cnt - b_wr);
        end
        checks++;
        if (last_data !== 16'hFC01) begin
            errors++;
            $display("FAIL clean1_data: got %h want fc01", last_data);
        end
        vs_pulse();
        checks++;
        if (Frame_Width !== 16'd8 || Frame_Height !== 16'd4 || Locked !== 1'b1) begin
            errors++;
            $display("FAIL clean1_report: got w=%0d h=%0d l=%b want 8 4 1", Frame_Width, Frame_Height, Locked);
        end
        b_wr = wr_cnt;
        send_frame(-1, 0, 8'h12, 8'h34, 8'h56);
        checks++;
        if (wr_cnt - b_wr !== 32 || last_data !== 16'h11AA) begin
            errors++;
            $display("FAIL clean2_writes: got n=%0d d=%h want 32 11aa", wr_cnt - b_wr, last_data);
        end
        vs_pulse();
        checks++;
        if (Locked !== 1'b1) begin
            errors++;
            $display("FAIL clean2_locked: got %b want 1", Locked);
        end
        send_frame(-1, 0, 8'hFF, 8'hFF, 8'hFF);
        checks++;
        if (last_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL clean3_data: got %h want ffff", last_data);
        end
        vs_pulse();
        checks++;
        if (Locked !== 1'b1 || Frame_Width !== 16'd8 || Frame_Height !== 16'd4) begin
            errors++;
            $display("FAIL clean3_report: got w=%0d h=%0d l=%b want 8 4 1", Frame_Width, Frame_Height, Locked);
        end
    endtask

    task automatic test_short_line();
        b_wr = wr_cnt;
        send_frame(2, 7, 8'h40, 8'h40, 8'h40);
        checks++;
        if (wr_cnt - b_wr !== 31) begin
            errors++;
            $display("FAIL short_writes: got %0d want 31", wr_cnt - b_wr);
        end
        vs_pulse();
        checks++;
        if (Locked !== 1'b0 || Frame_Width !== 16'd8 || Frame_Height !== 16'd4) begin
            errors++;
            $display("FAIL short_report: got w=%0d h=%0d l=%b want 8 4 0", Frame_Width, Frame_Height, Locked);
        end
        send_frame(-1, 0, 8'h40, 8'h40, 8'h40);
        vs_pulse();
        checks++;
        if (Locked !== 1'b1) begin
            errors++;
            $display("FAIL short_recover: got %b want 1", Locked);
        end
    endtask

    task automatic test_overflow();
        b_wr = wr_cnt;
        send_line(8, 8'h11, 8'h22, 8'h33, 0, 0);
        send_line(8, 8'h11, 8'h22, 8'h33, 2, 5);
        send_line(8, 8'h11, 8'h22, 8'h33, 0, 0);
        send_line(8, 8'h11, 8'h22, 8'h33, 0, 0);
        checks++;
        if (wr_cnt - b_wr !== 27) begin
            errors++;
            $display("FAIL ovf_writes: got %0d want 27", wr_cnt - b_wr);
        end
        checks++;
        if (Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b want 1", Overflow);
        end
        vs_pulse();
        checks++;
        if (Locked !== 1'b0 || Overflow !== 1'b1 || Frame_Width !== 16'd8 || Frame_Height !== 16'd4) begin
            errors++;
            $display("FAIL ovf_report: got w=%0d h=%0d l=%b o=%b want 8 4 0 1",
                     Frame_Width, Frame_Height, Locked, Overflow);
        end
        send_frame(-1, 0, 8'h11, 8'h22, 8'h33);
        vs_pulse();
        checks++;
        if (Locked !== 1'b1 || Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got l=%b o=%b want 1 1", Locked, Overflow);
        end
        Clr_Ovf = 1'b1;
        tick(1);
        Clr_Ovf = 1'b0;
        checks++;
        if (Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", Overflow);
        end
    endtask

    task automatic test_fifo_rst();
        b_wr = wr_cnt; b_rst = rst_cycles; b_wir = we_in_rst;
        LCD_VSYNC = 1'b1;
        tick(1);
        checks++;
        if (Frame_Start !== 1'b1 || FIFO_RST !== 1'b1) begin
            errors++;
            $display("FAIL edge_pulse: got fs=%b rst=%b want 1 1", Frame_Start, FIFO_RST);
        end
        tick(1);
        checks++;
        if (Frame_Start !== 1'b0) begin
            errors++;
            $display("FAIL edge_one_cycle: got %b want 0", Frame_Start);
        end
        LCD_VSYNC = 1'b0;
        LCD_R = 8'h08; LCD_G = 8'h04; LCD_B = 8'h08;
        LCD_DE = 1'b1;
        tick(30);
        LCD_DE = 1'b0;
        tick(5);
        checks++;
        if (rst_cycles - b_rst !== 20) begin
            errors++;
            $display("FAIL fifo_rst_len: got %0d want 20", rst_cycles - b_rst);
        end
        checks++;
        if (we_in_rst - b_wir !== 0) begin
            errors++;
            $display("FAIL we_during_rst: got %0d want 0", we_in_rst - b_wir);
        end
        checks++;
        if (wr_cnt - b_wr !== 12 || last_data !== 16'h0821) begin
            errors++;
            $display("FAIL rst_tail_writes: got n=%0d d=%h want 12 0821", wr_cnt - b_wr, last_data);
        end
        checks++;
        if (Frame_Height !== 16'd0 || Locked !== 1'b0) begin
            errors++;
            $display("FAIL empty_frame: got h=%0d l=%b want 0 0", Frame_Height, Locked);
        end
        vs_pulse();
        checks++;
        if (Frame_Width !== 16'd30 || Frame_Height !== 16'd1 || Locked !== 1'b0) begin
            errors++;
            $display("FAIL wide_report: got w=%0d h=%0d l=%b want 30 1 0", Frame_Width, Frame_Height, Locked);
        end
    endtask

    task automatic test_vs_abort();
        b_wr = wr_cnt;
        send_line(8, 8'h20, 8'h20, 8'h20, 0, 0);
        LCD_DE = 1'b1;
        tick(4);
        LCD_VSYNC = 1'b1;
        tick(1);
        LCD_DE = 1'b0;
        tick(2);
        LCD_VSYNC = 1'b0;
        tick(25);
        checks++;
        if (wr_cnt - b_wr !== 12) begin
            errors++;
            $display("FAIL abort_writes: got %0d want 12", wr_cnt - b_wr);
        end
        checks++;
        if (Frame_Width !== 16'd8 || Frame_Height !== 16'd2 || Locked !== 1'b0) begin
            errors++;
            $display("FAIL abort_report: got w=%0d h=%0d l=%b want 8 2 0", Frame_Width, Frame_Height, Locked);
        end
    endtask

    task automatic test_reset_mid_line();
        send_frame(-1, 0, 8'h55, 8'h55, 8'h55);
        vs_pulse();
        checks++;
        if (Locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_locked: got %b want 1", Locked);
        end
        LCD_DE = 1'b1;
        tick(3);
        checks++;
        if (FIFO_WE !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_we: got %b want 1", FIFO_WE);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if ({FIFO_WE, FIFO_RST, Frame_Start, Locked, Overflow} !== 5'b0 ||
            {Frame_Width, Frame_Height, FIFO_Data} !== 48'h0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b w=%0d h=%0d d=%h want all 0",
                     {FIFO_WE, FIFO_RST, Frame_Start, Locked, Overflow}, Frame_Width, Frame_Height, FIFO_Data);
        end
        b_wr = wr_cnt;
        tick(1);
        nRST = 1'b1;
        tick(5);
        LCD_DE = 1'b0;
        tick(5);
        send_line(8, 8'h55, 8'h55, 8'h55, 0, 0);
        checks++;
        if (wr_cnt - b_wr !== 0) begin
            errors++;
            $display("FAIL post_reset_writes: got %0d want 0", wr_cnt - b_wr);
        end
        vs_pulse();
        checks++;
        if (Locked !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_edge: got %b want 0", Locked);
        end
        b_wr = wr_cnt;
        send_frame(-1, 0, 8'h55, 8'h55, 8'h55);
        vs_pulse();
        checks++;
        if (wr_cnt - b_wr !== 32 || Locked !== 1'b1 || Frame_Width !== 16'd8 || Frame_Height !== 16'd4) begin
            errors++;
            $display("FAIL post_reset_frame: got n=%0d w=%0d h=%0d l=%b want 32 8 4 1",
                     wr_cnt - b_wr, Frame_Width, Frame_Height, Locked);
        end
    endtask

    initial begin
        test_reset();
        test_wait_vs();
        test_clean_frames();
        test_short_line();
        test_overflow();
        test_fifo_rst();
        test_vs_abort();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
